msx_kbd_matrix: RTL
===================

Name: msx_kbd_matrix

Overview:
- Converts MiSTer `ps2_key` events into the 11-row x 8-column MSX keyboard matrix.
- Serves the matrix to the 8255 PPI: PPI port C[3:0] selects a row; the block returns that row's columns, active low, on PPI port B input.
- Sits directly upstream of `jt8255` and replaces the constant `portb_din` tie-off in the top level.

Parameters:
- ROWS, 11, number of implemented matrix rows; row indices ROWS..15 read as 8'hFF.

Ports:
- clk  in  1  system clock (same clock as CPU/PPI)
- reset_n  in  1  synchronous, active-low reset
- ps2_key  in  11  [10] toggles per event, [9] 1=make/0=break, [8] E0-extended, [7:0] scancode
- release_all  in  1  level; while high, clears all keys (host focus loss / OSD open)
- kbd_row  in  4  PPI port C[3:0], row select
- kbd_cols_n  out  8  PPI port B input, column bits for selected row, 0 = pressed
- key_event  out  1  one-cycle pulse when a mapped event updates the matrix

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - matrix cleared (no key pressed); kbd_cols_n=8'hFF; key_event=0.
  - toggle history register loaded from ps2_key[10]; arm flag cleared.
- Toggle detection:
  - First cycle after reset: reload history, set arm, no event. This guarantees no spurious event from a stale toggle level.
  - Afterwards: event when ps2_key[10] != history; history updates every cycle.
- Pipeline:
  - S1: latch {make, ext, code} on event.
  - S2: combinational table lookup registered as {hit, row[3:0], col[2:0]}.
  - S3: if hit, matrix[row][col] <= make; key_event pulses in the same cycle.
- Latency: toggle edge at cycle N -> matrix bit updated at edge N+3 -> visible on kbd_cols_n at N+4.
- Back-to-back events on consecutive cycles are all processed in order (fully pipelined, no stall).
- Mandatory map, shown as scancode -> row/col:
  - Digits 0..7: 45,16,1E,26,25,2E,36,3D -> row0 col0..7.
  - A 1C -> r2c6; B 32 -> r2c7.
  - Shift 12 (left) or 59 (right) -> r6c0; Ctrl 14 -> r6c1; Graph 11 -> r6c2; Caps 58 -> r6c3.
  - Esc 76 -> r7c2; Tab 0D -> r7c3; BS 66 -> r7c5; Return 5A -> r7c7.
  - Space 29 -> r8c0.
  - Extended (ext=1): Home 6C -> r8c1; Ins 70 -> r8c2; Del 71 -> r8c3; Left 6B -> r8c4; Up 75 -> r8c5; Down 72 -> r8c6; Right 74 -> r8c7.
  - Remaining entries follow the MSX international matrix. Unmapped codes: hit=0, no update, no key_event.
- Lookup keys on {ext, code}: E0-74 and plain 74 are distinct entries.
- Shift: left and right shift are held in separate flags; r6c0 = left OR right. Releasing one shift while the other is held keeps the bit pressed.
- release_all:
  - Clears the matrix and shift flags at the next edge and overrides any S3 update in the same cycle; that event is discarded with no key_event.
  - Held high: matrix stays clear.
- Readout:
  - kbd_cols_n <= ~matrix[kbd_row] registered, 1-cycle latency.
  - kbd_row >= ROWS -> 8'hFF.
  - Row-change and matrix-update in the same cycle: new row with new contents appear together, one cycle later.
- Reset mid-pipeline: all in-flight S1/S2 entries are discarded.

Optional Feature:
- MSX_KBD_GHOST_EN
  - Defined: one-level matrix ghosting. Output = ~(matrix[sel] | OR of matrix[r] over every r != sel where (matrix[r] & matrix[sel]) != 0). Computed combinationally before the output register; latency is unchanged.
  - Undefined: plain readout of the selected row only.

Test Plan:
- Reset with ps2_key[10]=1 held, release reset -> no key_event, kbd_cols_n=FF for every row 0..15.
- Toggle with make, code 1C, kbd_row=2 -> key_event at N+3, kbd_cols_n=8'hBF at N+4. Break 1C -> 8'hFF.
- Make E0-75 (Up) then make plain 75 -> row8 reads 8'hDF. Plain 75 does not touch row8. Break E0-75 -> 8'hFF.
- Make 12, make 59, break 12 -> row6 = 8'hFE. Break 59 -> 8'hFF.
- Press 29 (space), then raise release_all in the same cycle as S3 of make 16 -> row8=FF, row0=FF, no key_event pulse for 16. Also kbd_row=11 -> FF always.
- With MSX_KBD_GHOST_EN: press r0c1, r0c2, r1c1, select row1 -> 8'hF9. Without the macro -> 8'hFD.

Source files
------------

// File: rtl/msx_kbd_matrix.sv
// msx_kbd_matrix: MiSTer ps2_key events -> 11x8 MSX key matrix, served to the PPI (row in, cols_n out).
// Toggle->matrix 3 edges, ->kbd_cols_n 4; never stalls. `define MSX_KBD_GHOST_EN adds one-level ghosting.
module msx_kbd_matrix #(
  parameter int ROWS = 11
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic        release_all,
  input  logic [3:0]  kbd_row,
  output logic [7:0]  kbd_cols_n,
  output logic        key_event
);

  logic [10:0]          ps2_q, ps2_d;
  logic                 tog_hist_q, tog_hist_d;
  logic                 armed_q, armed_d;
  logic                 evt;
  logic                 s1_vld_q, s1_vld_d;
  logic [9:0]           s1_key_q, s1_key_d;
  logic                 s2_vld_q, s2_vld_d;
  logic                 s2_hit_q, s2_hit_d;
  logic [3:0]           s2_row_q, s2_row_d;
  logic [2:0]           s2_col_q, s2_col_d;
  logic                 s2_make_q, s2_make_d;
  logic                 s2_shl_q, s2_shl_d;
  logic                 s2_shr_q, s2_shr_d;
  logic                 shift_l_q, shift_l_d;
  logic                 shift_r_q, shift_r_d;
  logic [ROWS-1:0][7:0] matrix_q, matrix_d;
  logic [7:0]           kbd_cols_n_q, kbd_cols_n_d;
  logic                 key_event_q, key_event_d;
  logic [7:0]           lk;
  logic [7:0]           sel_row;
  logic [7:0]           read_row;
  logic                 wr_bit;

  function automatic logic [7:0] rc(input int r, input int c);
    return {1'b1, 4'(r), 3'(c)};
  endfunction

  // Key is {ext, code}; extended and plain codes are separate entries.
  always_comb begin
    lk = 8'h00;
    case (s1_key_q[8:0])
      9'h045: lk = rc(0, 0);  9'h016: lk = rc(0, 1);  9'h01E: lk = rc(0, 2);  9'h026: lk = rc(0, 3);
      9'h025: lk = rc(0, 4);  9'h02E: lk = rc(0, 5);  9'h036: lk = rc(0, 6);  9'h03D: lk = rc(0, 7);
      9'h03E: lk = rc(1, 0);  9'h046: lk = rc(1, 1);  9'h04E: lk = rc(1, 2);  9'h055: lk = rc(1, 3);
      9'h05D: lk = rc(1, 4);  9'h054: lk = rc(1, 5);  9'h05B: lk = rc(1, 6);  9'h04C: lk = rc(1, 7);
      9'h052: lk = rc(2, 0);  9'h00E: lk = rc(2, 1);  9'h041: lk = rc(2, 2);  9'h049: lk = rc(2, 3);
      9'h04A: lk = rc(2, 4);  9'h061: lk = rc(2, 5);  9'h01C: lk = rc(2, 6);  9'h032: lk = rc(2, 7);
      9'h021: lk = rc(3, 0);  9'h023: lk = rc(3, 1);  9'h024: lk = rc(3, 2);  9'h02B: lk = rc(3, 3);
      9'h034: lk = rc(3, 4);  9'h033: lk = rc(3, 5);  9'h043: lk = rc(3, 6);  9'h03B: lk = rc(3, 7);
      9'h042: lk = rc(4, 0);  9'h04B: lk = rc(4, 1);  9'h03A: lk = rc(4, 2);  9'h031: lk = rc(4, 3);
      9'h044: lk = rc(4, 4);  9'h04D: lk = rc(4, 5);  9'h015: lk = rc(4, 6);  9'h02D: lk = rc(4, 7);
      9'h01B: lk = rc(5, 0);  9'h02C: lk = rc(5, 1);  9'h03C: lk = rc(5, 2);  9'h02A: lk = rc(5, 3);
      9'h01D: lk = rc(5, 4);  9'h022: lk = rc(5, 5);  9'h035: lk = rc(5, 6);  9'h01A: lk = rc(5, 7);
      9'h012: lk = rc(6, 0);  9'h059: lk = rc(6, 0);  9'h014: lk = rc(6, 1);  9'h011: lk = rc(6, 2);
      9'h058: lk = rc(6, 3);  9'h111: lk = rc(6, 4);  9'h005: lk = rc(6, 5);  9'h006: lk = rc(6, 6);
      9'h004: lk = rc(6, 7);
      9'h00C: lk = rc(7, 0);  9'h003: lk = rc(7, 1);  9'h076: lk = rc(7, 2);  9'h00D: lk = rc(7, 3);
      9'h007: lk = rc(7, 4);  9'h066: lk = rc(7, 5);  9'h00A: lk = rc(7, 6);  9'h05A: lk = rc(7, 7);
      9'h029: lk = rc(8, 0);  9'h16C: lk = rc(8, 1);  9'h170: lk = rc(8, 2);  9'h171: lk = rc(8, 3);
      9'h16B: lk = rc(8, 4);  9'h175: lk = rc(8, 5);  9'h172: lk = rc(8, 6);  9'h174: lk = rc(8, 7);
      9'h07C: lk = rc(9, 0);  9'h079: lk = rc(9, 1);  9'h14A: lk = rc(9, 2);  9'h070: lk = rc(9, 3);
      9'h069: lk = rc(9, 4);  9'h072: lk = rc(9, 5);  9'h07A: lk = rc(9, 6);  9'h06B: lk = rc(9, 7);
      9'h073: lk = rc(10, 0); 9'h074: lk = rc(10, 1); 9'h06C: lk = rc(10, 2); 9'h075: lk = rc(10, 3);
      9'h07D: lk = rc(10, 4); 9'h07B: lk = rc(10, 5); 9'h071: lk = rc(10, 7);
      default: lk = 8'h00;
    endcase
  end

  // ps2_key is registered once before edge detection; armed_q masks the first cycle after reset.
  always_comb begin
    ps2_d      = ps2_key;
    tog_hist_d = ps2_q[10];
    armed_d    = 1'b1;
    evt        = armed_q && (ps2_q[10] != tog_hist_q);
    s1_vld_d   = evt;
    s1_key_d   = evt ? ps2_q[9:0] : s1_key_q;
    s2_vld_d   = s1_vld_q;
    {s2_hit_d, s2_row_d, s2_col_d} = lk;
    s2_make_d  = s1_key_q[9];
    s2_shl_d   = (s1_key_q[8:0] == 9'h012);
    s2_shr_d   = (s1_key_q[8:0] == 9'h059);
  end

  always_comb begin
    matrix_d    = matrix_q;
    shift_l_d   = shift_l_q;
    shift_r_d   = shift_r_q;
    key_event_d = 1'b0;
    wr_bit      = s2_make_q;
    if (release_all) begin
      matrix_d  = '0;
      shift_l_d = 1'b0;
      shift_r_d = 1'b0;
    end else if (s2_vld_q && s2_hit_q) begin
      key_event_d = 1'b1;
      if (s2_shl_q) shift_l_d = s2_make_q;
      if (s2_shr_q) shift_r_d = s2_make_q;
      if (s2_shl_q || s2_shr_q) wr_bit = shift_l_d | shift_r_d;
      for (int r = 0; r < ROWS; r++) begin
        if (s2_row_q == 4'(r)) matrix_d[r][s2_col_q] = wr_bit;
      end
    end
  end

  // Rows at or beyond ROWS leave sel_row at zero and so read back as all released.
  always_comb begin
    sel_row = 8'h00;
    for (int r = 0; r < ROWS; r++) begin
      if (kbd_row == 4'(r)) sel_row = matrix_q[r];
    end
    read_row = sel_row;
`ifdef MSX_KBD_GHOST_EN
    for (int r = 0; r < ROWS; r++) begin
      if ((kbd_row != 4'(r)) && (|(matrix_q[r] & sel_row))) read_row = read_row | matrix_q[r];
    end
`endif
    kbd_cols_n_d = ~read_row;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ps2_q        <= ps2_key;
      tog_hist_q   <= ps2_key[10];
      armed_q      <= 1'b0;
      s1_vld_q     <= 1'b0;
      s1_key_q     <= '0;
      s2_vld_q     <= 1'b0;
      s2_hit_q     <= 1'b0;
      s2_row_q     <= '0;
      s2_col_q     <= '0;
      s2_make_q    <= 1'b0;
      s2_shl_q     <= 1'b0;
      s2_shr_q     <= 1'b0;
      shift_l_q    <= 1'b0;
      shift_r_q    <= 1'b0;
      matrix_q     <= '0;
      kbd_cols_n_q <= 8'hFF;
      key_event_q  <= 1'b0;
    end else begin
      ps2_q        <= ps2_d;
      tog_hist_q   <= tog_hist_d;
      armed_q      <= armed_d;
      s1_vld_q     <= s1_vld_d;
      s1_key_q     <= s1_key_d;
      s2_vld_q     <= s2_vld_d;
      s2_hit_q     <= s2_hit_d;
      s2_row_q     <= s2_row_d;
      s2_col_q     <= s2_col_d;
      s2_make_q    <= s2_make_d;
      s2_shl_q     <= s2_shl_d;
      s2_shr_q     <= s2_shr_d;
      shift_l_q    <= shift_l_d;
      shift_r_q    <= shift_r_d;
      matrix_q     <= matrix_d;
      kbd_cols_n_q <= kbd_cols_n_d;
      key_event_q  <= key_event_d;
    end
  end

  assign kbd_cols_n = kbd_cols_n_q;
  assign key_event  = key_event_q;

endmodule
